// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, talks to a ready-handshake imem, applies stall/redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_pc_plus4,
    output logic        IF_valid,
    output logic        fetch_wait,
    output logic        imem_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     ifpc_q, ifpc_d;
    logic [31:0]     ifpc4_q, ifpc4_d;
    logic            valid_q, valid_d;
    logic [31:0]     buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     pc_plus4;
    logic [31:0]     redir_aligned;

    assign pc_plus4      = pc_q + 32'd4;
    assign redir_aligned = {redirect_pc[31:2], 2'b00};

    assign imem_req    = rst && (state_q == S_FETCH);
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign fetch_wait  = (state_q == S_FETCH) && !imem_ready;
    assign IF_inst     = inst_q;
    assign IF_pc       = ifpc_q;
    assign IF_pc_plus4 = ifpc4_q;
    assign IF_valid    = valid_q;
    assign imem_err    = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_BOOT: begin
                if (redirect_en) pc_d = redir_aligned;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_en) begin
                    pc_d    = redir_aligned;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (imem_ready) begin
                    cnt_d = '0;
                    if (pc_stall_en) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        inst_d  = imem_rdata;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else begin
                    // Saturating run-length of consecutive not-ready cycles
                    if (cnt_q != CW'(MAX_WAIT)) cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(MAX_WAIT)) err_d = 1'b1;
                    if (!pc_stall_en) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    pc_d    = redir_aligned;
                    buf_d   = NOP_INST;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!pc_stall_en) begin
                    inst_d  = buf_q;
                    ifpc_d  = pc_q;
                    ifpc4_d = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            valid_q <= 1'b0;
            buf_q   <= NOP_INST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; imem returns addr>>2 for each word.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stall_en;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic [31:0] IF_pc_plus4;
    logic        IF_valid;
    logic        fetch_wait;
    logic        imem_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr >> 2;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_stall_en (pc_stall_en),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .IF_inst     (IF_inst),
        .IF_pc       (IF_pc),
        .IF_pc_plus4 (IF_pc_plus4),
        .IF_valid    (IF_valid),
        .fetch_wait  (fetch_wait),
        .imem_err    (imem_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        pc_stall_en = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        imem_ready = 1'b1;
        step();
        step();
        chk("rst_inst", IF_inst, 32'h0);
        chk("rst_pc", IF_pc, 32'h0);
        chk("rst_valid", 32'(IF_valid), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_err", 32'(imem_err), 32'h0);
        chk("rst_addr", imem_addr, 32'h3000);

        // 1. boot and zero-wait flow
        rst = 1'b1;
        #1;
        chk("boot_req", 32'(imem_req), 32'h0);
        step();
        chk("f0_req", 32'(imem_req), 32'h1);
        chk("f0_addr", imem_addr, 32'h3000);
        chk("f0_valid", 32'(IF_valid), 32'h0);
        step();
        chk("f1_inst", IF_inst, 32'hC00);
        chk("f1_pc", IF_pc, 32'h3000);
        chk("f1_pc4", IF_pc_plus4, 32'h3004);
        chk("f1_valid", 32'(IF_valid), 32'h1);
        chk("f1_addr", imem_addr, 32'h3004);
        step();
        chk("f2_inst", IF_inst, 32'hC01);
        chk("f2_addr", imem_addr, 32'h3008);

        // 2. stall two cycles
        pc_stall_en = 1'b1;
        step();
        chk("st1_req", 32'(imem_req), 32'h0);
        chk("st1_inst", IF_inst, 32'hC01);
        step();
        chk("st2_req", 32'(imem_req), 32'h0);
        chk("st2_inst", IF_inst, 32'hC01);
        chk("st2_valid", 32'(IF_valid), 32'h1);
        pc_stall_en = 1'b0;
        step();
        chk("rel_inst", IF_inst, 32'hC02);
        chk("rel_pc", IF_pc, 32'h3008);
        chk("rel_addr", imem_addr, 32'h300C);
        chk("rel_req", 32'(imem_req), 32'h1);
        step();
        chk("rel2_inst", IF_inst, 32'hC03);

        // 3. redirect during fetch
        redirect_en = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect_en = 1'b0;
        chk("rd_addr", imem_addr, 32'h3100);
        chk("rd_valid", 32'(IF_valid), 32'h0);
        chk("rd_inst", IF_inst, 32'h0);
        chk("rd_pc", IF_pc, 32'h300C);
        step();
        chk("rd2_inst", IF_inst, 32'hC40);
        chk("rd2_pc", IF_pc, 32'h3100);
        chk("rd2_valid", 32'(IF_valid), 32'h1);

        // 4. three wait cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("w_fwait", 32'(fetch_wait), 32'h1);
            step();
            chk("w_valid", 32'(IF_valid), 32'h0);
            chk("w_addr", imem_addr, 32'h3104);
        end
        imem_ready = 1'b1;
        #1;
        chk("w_fwait0", 32'(fetch_wait), 32'h0);
        step();
        chk("w_inst", IF_inst, 32'hC41);
        chk("w_pc", IF_pc, 32'h3104);
        chk("w_err", 32'(imem_err), 32'h0);

        // 5. timeout
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("to15_err", 32'(imem_err), 32'h0);
        step();
        chk("to16_err", 32'(imem_err), 32'h1);
        imem_ready = 1'b1;
        step();
        chk("to_sticky", 32'(imem_err), 32'h1);
        chk("to_inst", IF_inst, 32'hC42);

        // 6. redirect beats stall in hold; wrap at top of memory
        pc_stall_en = 1'b1;
        step();
        chk("h_req", 32'(imem_req), 32'h0);
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_en = 1'b0;
        pc_stall_en = 1'b0;
        chk("hr_valid", 32'(IF_valid), 32'h0);
        chk("hr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("hr_req", 32'(imem_req), 32'h1);
        step();
        chk("wrap_inst", IF_inst, 32'h3FFF_FFFF);
        chk("wrap_pc", IF_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", IF_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset while waiting
        imem_ready = 1'b0;
        step();
        step();
        chk("pre_fwait", 32'(fetch_wait), 32'h1);
        rst = 1'b0;
        #1;
        chk("rw_req_comb", 32'(imem_req), 32'h0);
        step();
        chk("rw_inst", IF_inst, 32'h0);
        chk("rw_pc", IF_pc, 32'h0);
        chk("rw_pc4", IF_pc_plus4, 32'h0);
        chk("rw_valid", 32'(IF_valid), 32'h0);
        chk("rw_err", 32'(imem_err), 32'h0);
        chk("rw_fwait", 32'(fetch_wait), 32'h0);
        chk("rw_addr", imem_addr, 32'h3000);
        rst = 1'b1;
        imem_ready = 1'b1;
        step();
        step();
        chk("rb_inst", IF_inst, 32'hC00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
